// File: rtl/pic_pkg.sv
// -----------------------------------------------------------------------------
// pic_pkg
// Shared definitions for the CPU-side PIC interrupt-acknowledge sequencer.
// It holds the FSM state encoding, the INTA and bus-direction polarity
// constants, the vector width and a small max helper used to size counters.
// This package has no ports.
// -----------------------------------------------------------------------------
package pic_pkg;

    localparam int VEC_W = 8;

    // INTA is active-low toward the PIC.
    localparam logic INTA_ACTIVE    = 1'b0;
    localparam logic INTA_IDLE      = 1'b1;

    // Data-bus direction as seen by the bus buffer.
    localparam logic DIR_CPU_DRIVES = 1'b1;
    localparam logic DIR_PIC_DRIVES = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_P1_LOW  = 3'd1,
        ST_GAP     = 3'd2,
        ST_P2_LOW  = 3'd3,
        ST_HOLD    = 3'd4,
        ST_RECOVER = 3'd5
    } pic_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/pic_inta_sequencer_sync.sv
// -----------------------------------------------------------------------------
// pic_int_sync
// SYNC_STAGES-deep flop chain that brings the asynchronous INT line into the
// clk domain. All flops clear on the synchronous active-high reset.
//   i_clk  : clock, rising edge
//   i_rst  : synchronous active-high reset
//   i_d    : asynchronous input
//   o_q    : synchronized output (last flop of the chain)
// -----------------------------------------------------------------------------
module pic_int_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_chain;

    // Shift the asynchronous input through the synchronizer chain.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/pic_inta_sequencer.sv
// -----------------------------------------------------------------------------
// pic_inta_sequencer
// Watches the PIC INT line, runs the two-pulse active-low INTA acknowledge
// cycle, turns the data bus toward the CPU during pulse 2, captures the
// vector the PIC drives and hands it to the core over valid/ready.
//
// Optional build macro: PIC_SPURIOUS_CHECK_EN
//   When defined, INT is re-checked on entry to pulse 2. If it has gone away
//   the pulse still completes but no vector is delivered; o_spurious pulses
//   for one cycle and an internal saturating counter r_spurious_cnt counts it.
//   When undefined the vector is always delivered and o_spurious is 0.
//
// Ports:
//   i_clk       : clock, rising edge
//   i_rst       : synchronous active-high reset
//   i_int_in    : INT from PIC, asynchronous, active-high
//   i_if_en     : CPU interrupt-enable flag
//   i_data_in   : vector from PIC bus buffer, valid during pulse 2
//   o_inta_n    : INTA to PIC, active-low
//   o_data_dir  : 1 = CPU drives bus, 0 = PIC drives bus
//   o_vec       : captured vector
//   o_vec_valid : vector available to core
//   i_vec_ready : core accepts vector
//   o_busy      : sequence in progress (state != IDLE)
//   o_spurious  : one-cycle spurious-interrupt flag
// -----------------------------------------------------------------------------
module pic_inta_sequencer
    import pic_pkg::*;
#(
    parameter int PULSE_W     = 2,
    parameter int GAP_W       = 2,
    parameter int SYNC_STAGES = 2,
    parameter int RECOVER_W   = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_int_in,
    input  logic             i_if_en,
    input  logic [VEC_W-1:0] i_data_in,
    output logic             o_inta_n,
    output logic             o_data_dir,
    output logic [VEC_W-1:0] o_vec,
    output logic             o_vec_valid,
    input  logic             i_vec_ready,
    output logic             o_busy,
    output logic             o_spurious
);

    localparam int CNT_W = $clog2(max3(PULSE_W, GAP_W, RECOVER_W) + 1);

    // Counters count down from W-1 so each state lasts exactly W cycles.
    localparam logic [CNT_W-1:0] PULSE_LD   = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LD     = CNT_W'(GAP_W - 1);
    localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'(RECOVER_W - 1);

    logic             w_int_s;
    logic             w_last;
    logic             w_spur;
    logic             w_deliver;
    pic_state_t       r_state;
    pic_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic             w_inta_n_nxt;
    logic             w_data_dir_nxt;
    logic [VEC_W-1:0] w_vec_nxt;
    logic             w_vec_valid_nxt;
    logic             w_busy_nxt;

    pic_int_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_int_in),
        .o_q   (w_int_s)
    );

    assign w_last = (r_cnt == '0);

`ifdef PIC_SPURIOUS_CHECK_EN
    logic       r_spur_flag;
    logic       r_spurious;
    logic [7:0] r_spurious_cnt;

    assign w_spur = r_spur_flag;

    // Latch the INT level seen on entry to pulse 2 and count spurious cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_spur_flag    <= 1'b0;
            r_spurious     <= 1'b0;
            r_spurious_cnt <= 8'd0;
        end else begin
            if ((r_state == ST_GAP) && (w_state_nxt == ST_P2_LOW)) begin
                r_spur_flag <= ~w_int_s;
            end else begin
                r_spur_flag <= r_spur_flag;
            end
            r_spurious <= (r_state == ST_P2_LOW) && w_last && r_spur_flag;
            if ((r_state == ST_P2_LOW) && w_last && r_spur_flag &&
                (r_spurious_cnt != 8'hFF)) begin
                r_spurious_cnt <= r_spurious_cnt + 8'd1;
            end else begin
                r_spurious_cnt <= r_spurious_cnt;
            end
        end
    end

    assign o_spurious = r_spurious;
`else
    assign w_spur     = 1'b0;
    assign o_spurious = 1'b0;
`endif

    // Vector is delivered on the last pulse-2 edge unless flagged spurious.
    assign w_deliver = (r_state == ST_P2_LOW) && w_last && !w_spur;

    // State, counter and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            o_inta_n    <= INTA_IDLE;
            o_data_dir  <= DIR_CPU_DRIVES;
            o_vec       <= '0;
            o_vec_valid <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            o_inta_n    <= w_inta_n_nxt;
            o_data_dir  <= w_data_dir_nxt;
            o_vec       <= w_vec_nxt;
            o_vec_valid <= w_vec_valid_nxt;
            o_busy      <= w_busy_nxt;
        end
    end

    // Next-state and counter reload; every state entry reloads the counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_int_s && i_if_en) begin
                    w_state_nxt = ST_P1_LOW;
                    w_cnt_nxt   = PULSE_LD;
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            ST_P1_LOW: begin
                if (w_last) begin
                    w_state_nxt = ST_GAP;
                    w_cnt_nxt   = GAP_LD;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            ST_GAP: begin
                if (w_last) begin
                    w_state_nxt = ST_P2_LOW;
                    w_cnt_nxt   = PULSE_LD;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            ST_P2_LOW: begin
                if (w_last && w_spur) begin
                    w_state_nxt = ST_RECOVER;
                    w_cnt_nxt   = RECOVER_LD;
                end else if (w_last) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            ST_HOLD: begin
                if (o_vec_valid && i_vec_ready) begin
                    w_state_nxt = ST_RECOVER;
                    w_cnt_nxt   = RECOVER_LD;
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            ST_RECOVER: begin
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output values for the next cycle, derived from the upcoming state.
    always_comb begin
        w_inta_n_nxt    = INTA_IDLE;
        w_data_dir_nxt  = DIR_CPU_DRIVES;
        w_vec_nxt       = o_vec;
        w_vec_valid_nxt = o_vec_valid;
        w_busy_nxt      = (w_state_nxt != ST_IDLE);

        if ((w_state_nxt == ST_P1_LOW) || (w_state_nxt == ST_P2_LOW)) begin
            w_inta_n_nxt = INTA_ACTIVE;
        end else begin
            w_inta_n_nxt = INTA_IDLE;
        end

        if (w_state_nxt == ST_P2_LOW) begin
            w_data_dir_nxt = DIR_PIC_DRIVES;
        end else begin
            w_data_dir_nxt = DIR_CPU_DRIVES;
        end

        if (w_deliver) begin
            w_vec_nxt       = i_data_in;
            w_vec_valid_nxt = 1'b1;
        end else if ((r_state == ST_HOLD) && o_vec_valid && i_vec_ready) begin
            w_vec_valid_nxt = 1'b0;
        end else begin
            w_vec_valid_nxt = o_vec_valid;
        end
    end

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pic_inta_sequencer
// Directed bench for pic_inta_sequencer with default parameters.
// -----------------------------------------------------------------------------
module tb_pic_inta_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       int_in;
    logic       if_en;
    logic [7:0] data_in;
    logic       inta_n;
    logic       data_dir;
    logic [7:0] vec;
    logic       vec_valid;
    logic       vec_ready;
    logic       busy;
    logic       spurious;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pic_inta_sequencer dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_int_in    (int_in),
        .i_if_en     (if_en),
        .i_data_in   (data_in),
        .o_inta_n    (inta_n),
        .o_data_dir  (data_dir),
        .o_vec       (vec),
        .o_vec_valid (vec_valid),
        .i_vec_ready (vec_ready),
        .o_busy      (busy),
        .o_spurious  (spurious)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic e_inta, input logic e_dir,
                            input logic e_valid, input logic e_busy);
        chk({tag, ".inta_n"}, {7'd0, inta_n}, {7'd0, e_inta});
        chk({tag, ".data_dir"}, {7'd0, data_dir}, {7'd0, e_dir});
        chk({tag, ".vec_valid"}, {7'd0, vec_valid}, {7'd0, e_valid});
        chk({tag, ".busy"}, {7'd0, busy}, {7'd0, e_busy});
    endtask

    // Called right after the edge that entered P1_LOW; stops after the
    // first P2_LOW edge's follow-up (i.e. in the last P2_LOW cycle).
    task automatic pulses(input string tag, input bit drop_int_p1, input bit drop_en_gap);
        if (drop_int_p1) int_in = 1'b0;
        tick(); chk_outs({tag, ".p1b"}, 1'b0, 1'b1, 1'b0, 1'b1);
        tick(); chk_outs({tag, ".gapa"}, 1'b1, 1'b1, 1'b0, 1'b1);
        if (drop_en_gap) if_en = 1'b0;
        tick(); chk_outs({tag, ".gapb"}, 1'b1, 1'b1, 1'b0, 1'b1);
        tick(); chk_outs({tag, ".p2a"}, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); chk_outs({tag, ".p2b"}, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic handoff(input string tag);
        vec_ready = 1'b1;
        tick(); chk_outs({tag, ".recover"}, 1'b1, 1'b1, 1'b0, 1'b1);
        vec_ready = 1'b0;
        tick(); chk_outs({tag, ".idle"}, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; int_in = 1'b1; if_en = 1'b1; data_in = 8'h4A; vec_ready = 1'b0;

        // Reset held with INT asserted: nothing moves.
        for (int i = 0; i < 3; i++) begin
            tick(); chk_outs("reset", 1'b1, 1'b1, 1'b0, 1'b0);
        end
        chk("reset.vec", vec, 8'h00);
        chk("reset.spurious", {7'd0, spurious}, 8'h00);
        rst = 1'b0;

        // Two edges of synchronizer latency, pulse 1 starts on the third.
        tick(); chk_outs("lat1", 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); chk_outs("lat2", 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); chk_outs("lat3.p1a", 1'b0, 1'b1, 1'b0, 1'b1);

        // Basic sequence delivering 8'h4A.
        pulses("basic", 1'b0, 1'b0);
        tick(); chk_outs("basic.hold", 1'b1, 1'b1, 1'b1, 1'b1);
        chk("basic.vec", vec, 8'h4A);

        // Backpressure: vector held, no new INTA while INT stays high.
        data_in = 8'h11;
        for (int i = 0; i < 5; i++) begin
            tick(); chk_outs("bp.hold", 1'b1, 1'b1, 1'b1, 1'b1);
            chk("bp.vec", vec, 8'h4A);
        end
        data_in = 8'h5B;
        handoff("bp");
        tick(); chk_outs("bp.p1a", 1'b0, 1'b1, 1'b0, 1'b1);
        pulses("seq2", 1'b0, 1'b0);
        tick(); chk_outs("seq2.hold", 1'b1, 1'b1, 1'b1, 1'b1);
        chk("seq2.vec", vec, 8'h5B);

        // Enable gating: no pulses while if_en is low.
        vec_ready = 1'b1;
        tick(); chk_outs("gate.recover", 1'b1, 1'b1, 1'b0, 1'b1);
        vec_ready = 1'b0; if_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(); chk_outs("gate.off", 1'b1, 1'b1, 1'b0, 1'b0);
        end
        if_en = 1'b1; data_in = 8'hC3;
        tick(); chk_outs("gate.p1a", 1'b0, 1'b1, 1'b0, 1'b1);
        pulses("gate", 1'b0, 1'b1);
        tick(); chk_outs("gate.hold", 1'b1, 1'b1, 1'b1, 1'b1);
        chk("gate.vec", vec, 8'hC3);
        handoff("gate");
        tick(); chk_outs("gate.stay_idle", 1'b1, 1'b1, 1'b0, 1'b0);

        // Reset in the second P2_LOW cycle abandons the sequence.
        if_en = 1'b1; data_in = 8'h77;
        tick(); chk_outs("rmid.p1a", 1'b0, 1'b1, 1'b0, 1'b1);
        pulses("rmid", 1'b0, 1'b0);
        rst = 1'b1;
        tick(); chk_outs("rmid.rst", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("rmid.vec", vec, 8'h00);
        rst = 1'b0; int_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); chk_outs("rmid.after", 1'b1, 1'b1, 1'b0, 1'b0);
        end

        // INT withdrawn early in pulse 1 so the two-flop synchronizer has
        // settled low by the time pulse 2 is entered.
        int_in = 1'b1; data_in = 8'h9E;
        tick(); tick();
        tick(); chk_outs("spur.p1a", 1'b0, 1'b1, 1'b0, 1'b1);
        pulses("spur", 1'b1, 1'b0);
`ifdef PIC_SPURIOUS_CHECK_EN
        tick(); chk_outs("spur.end", 1'b1, 1'b1, 1'b0, 1'b1);
        chk("spur.flag", {7'd0, spurious}, 8'h01);
        chk("spur.vec", vec, 8'h00);
        chk("spur.cnt", dut.r_spurious_cnt, 8'h01);
        tick(); chk_outs("spur.idle", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("spur.flag_drop", {7'd0, spurious}, 8'h00);
`else
        tick(); chk_outs("spur.hold", 1'b1, 1'b1, 1'b1, 1'b1);
        chk("spur.flag", {7'd0, spurious}, 8'h00);
        chk("spur.vec", vec, 8'h9E);
        handoff("spur");
        tick(); chk_outs("spur.stay_idle", 1'b1, 1'b1, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
